// File: rtl/dlx_mem_responder_if.sv
// Bus bundle between the DLX memory access controller (master) and a memory responder (slave).
// AS_N/WR_N/ADDR/DI flow towards the responder; DO/ACK_N flow back.
interface dlx_mem_responder_if;
    logic        AS_N;
    logic        WR_N;
    logic [31:0] ADDR;
    logic [31:0] DI;
    logic [31:0] DO;
    logic        ACK_N;

    modport master (output AS_N, WR_N, ADDR, DI, input  DO, ACK_N);
    modport slave  (input  AS_N, WR_N, ADDR, DI, output DO, ACK_N);
endinterface

// File: rtl/dlx_mem_responder.sv
// Slave end of the DLX AS_N/WR_N/ACK_N handshake: captures a strobed request, waits a fixed
// number of cycles, performs the word access on an internal RAM and pulses ACK_N for one cycle.
module dlx_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    dlx_mem_responder_if.slave bus,
    output logic [1:0]         RESP_STATE
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        ACK     = 2'b10,
        RELEASE = 2'b11
    } state_t;

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state;
    state_t            next_state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] idx_q;
    logic              wr_n_q;
    logic [31:0]       di_q;
    logic [31:0]       do_q;
    logic              ack_n_q;
    logic [31:0]       mem [DEPTH];

    logic              capture;
    logic              enter_ack;
    logic [ADDR_W-1:0] cur_idx;
    logic              cur_wr_n;
    logic [31:0]       cur_di;
    logic              unused_addr;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!bus.AS_N) next_state = (WAIT_CYCLES == 0) ? ACK : WAIT;
            WAIT:    if (wait_cnt == 4'd0) next_state = ACK;
            ACK:     next_state = RELEASE;
            RELEASE: if (bus.AS_N) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With no wait states the capture edge is also the access edge, so the live bus
    // values bypass the capture registers.
    always_comb begin
        capture     = (state == IDLE) && !bus.AS_N;
        enter_ack   = (next_state == ACK) && (state != ACK);
        cur_idx     = capture ? bus.ADDR[ADDR_W+1:2] : idx_q;
        cur_wr_n    = capture ? bus.WR_N : wr_n_q;
        cur_di      = capture ? bus.DI : di_q;
        RESP_STATE  = state;
        bus.DO      = do_q;
        bus.ACK_N   = ack_n_q;
        unused_addr = ^{bus.ADDR[31:ADDR_W+2], bus.ADDR[1:0]};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt <= 4'd0;
            idx_q    <= '0;
            wr_n_q   <= 1'b1;
            di_q     <= 32'h0;
            do_q     <= 32'h0;
            ack_n_q  <= 1'b1;
        end else begin
            ack_n_q <= (next_state != ACK);
            if (capture) begin
                idx_q    <= bus.ADDR[ADDR_W+1:2];
                wr_n_q   <= bus.WR_N;
                di_q     <= bus.DI;
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_ack && cur_wr_n) begin
                do_q <= mem[cur_idx];
            end
        end
    end

    // RAM contents survive reset; only the write enable is suppressed while RESET is high.
    always_ff @(posedge CLK) begin
        if (enter_ack && !cur_wr_n && !RESET) begin
            mem[cur_idx] <= cur_di;
        end
    end
endmodule

// File: tb/tb_dlx_mem_responder.sv
// Bench for dlx_mem_responder: one instance with two wait states and one with none, driven by
// directed and random transactions; a monitor checks every acknowledge against a queued expectation.
module tb_dlx_mem_responder;
    typedef struct {
        bit          is_rd;
        logic [31:0] do_exp;
        int          ack_cycle;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  as_n;
    logic [1:0]  wr_n;
    logic [31:0] addr [2];
    logic [31:0] di [2];
    logic [1:0]  ack_n;
    logic [31:0] dout [2];
    logic [1:0]  st [2];
    logic [1:0]  st_w2;
    logic [1:0]  st_w0;

    int          cycle = 0;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] model_mem [int];
    logic [31:0] last_do [2];
    bit          prev_low [2];

    dlx_mem_responder_if bus_w2 ();
    dlx_mem_responder_if bus_w0 ();

    assign bus_w2.AS_N = as_n[0];
    assign bus_w2.WR_N = wr_n[0];
    assign bus_w2.ADDR = addr[0];
    assign bus_w2.DI   = di[0];
    assign bus_w0.AS_N = as_n[1];
    assign bus_w0.WR_N = wr_n[1];
    assign bus_w0.ADDR = addr[1];
    assign bus_w0.DI   = di[1];
    assign ack_n[0]    = bus_w2.ACK_N;
    assign ack_n[1]    = bus_w0.ACK_N;
    assign dout[0]     = bus_w2.DO;
    assign dout[1]     = bus_w0.DO;
    assign st[0]       = st_w2;
    assign st[1]       = st_w0;

    dlx_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_w2 (
        .CLK(CLK), .RESET(RESET), .bus(bus_w2), .RESP_STATE(st_w2)
    );
    dlx_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_w0 (
        .CLK(CLK), .RESET(RESET), .bus(bus_w0), .RESP_STATE(st_w0)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    function automatic int wait_of(input int s);
        return (s == 0) ? 2 : 0;
    endfunction

    // Word index wraps modulo the 256-word RAM; each instance has its own key range.
    function automatic int key(input int s, input logic [31:0] a);
        return s * 1024 + int'(a[9:2]);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic apply_stimulus(input int s, input bit is_wr, input logic [31:0] a,
                                  input logic [31:0] d, input int hold, input bit scramble);
        exp_t e;
        int   w;
        w = wait_of(s);
        @(posedge CLK);
        #2;
        as_n[s] = 1'b0;
        wr_n[s] = ~is_wr;
        addr[s] = a;
        di[s]   = d;
        e.is_rd     = !is_wr;
        e.ack_cycle = cycle + 1 + w;
        if (is_wr) model_mem[key(s, a)] = d;
        else       last_do[s] = model_mem[key(s, a)];
        e.do_exp = last_do[s];
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
        for (int k = 1; k <= w + 1; k++) begin
            @(posedge CLK);
            if (scramble && k == 1) begin
                #2;
                wr_n[s] = ~wr_n[s];
                di[s]   = ~d;
            end
            @(negedge CLK);
            check_output("busy_state", 32'(st[s]), (k <= w) ? 32'h1 : 32'h2);
        end
        for (int i = 0; i <= hold; i++) begin
            @(negedge CLK);
            check_output("release_state", 32'(st[s]), 32'h3);
        end
        as_n[s] = 1'b1;
        @(negedge CLK);
        check_output("idle_after_release", 32'(st[s]), 32'h0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RESET) begin
            prev_low[0] = 1'b0;
            prev_low[1] = 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (prev_low[s]) check_output("ack_pulse_width", 32'(ack_n[s]), 32'h1);
                if (ack_n[s] == 1'b0) begin
                    if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
                        check_output("unexpected_ack", 32'(ack_n[s]), 32'h1);
                    end else begin
                        if (s == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check_output("ack_latency", cycle, e.ack_cycle);
                        if (e.is_rd) check_output("read_data", dout[s], e.do_exp);
                        else         check_output("do_hold_on_write", dout[s], e.do_exp);
                    end
                end
                prev_low[s] = (ack_n[s] == 1'b0);
            end
        end
    end

    initial begin
        int          s;
        bit          is_wr;
        logic [31:0] a;
        RESET      = 1'b1;
        as_n       = 2'b11;
        wr_n       = 2'b11;
        addr[0]    = 32'h0;
        addr[1]    = 32'h0;
        di[0]      = 32'h0;
        di[1]      = 32'h0;
        last_do[0] = 32'h0;
        last_do[1] = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            check_output("reset_ack_n", 32'(ack_n[i]), 32'h1);
            check_output("reset_do", dout[i], 32'h0);
            check_output("reset_state", 32'(st[i]), 32'h0);
        end
        RESET = 1'b0;

        apply_stimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);
        apply_stimulus(0, 1'b1, 32'h14, 32'h1, 0, 1'b0);
        apply_stimulus(0, 1'b1, 32'h0000_0404, 32'hA5A5A5A5, 0, 1'b0);
        apply_stimulus(0, 1'b0, 32'h0000_0004, 32'h0, 0, 1'b0);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 10, 1'b0);
        apply_stimulus(0, 1'b1, 32'h40, 32'h600DF00D, 0, 1'b1);
        apply_stimulus(0, 1'b0, 32'h40, 32'h0, 0, 1'b0);

        // Abort a write one cycle after capture; the RAM word must keep its old value.
        apply_stimulus(0, 1'b1, 32'h20, 32'h0, 0, 1'b0);
        @(posedge CLK);
        #2;
        as_n[0] = 1'b0;
        wr_n[0] = 1'b0;
        addr[0] = 32'h20;
        di[0]   = 32'h12345678;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check_output("abort_ack_n", 32'(ack_n[0]), 32'h1);
        check_output("abort_state", 32'(st[0]), 32'h0);
        as_n[0]    = 1'b1;
        last_do[0] = 32'h0;
        last_do[1] = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        apply_stimulus(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);

        apply_stimulus(1, 1'b1, 32'h30, 32'hCAFEF00D, 0, 1'b1);
        apply_stimulus(1, 1'b0, 32'h30, 32'h0, 0, 1'b0);
        apply_stimulus(1, 1'b0, 32'h1030, 32'h0, 3, 1'b0);

        for (int n = 0; n < 80; n++) begin
            s = int'($urandom_range(1, 0));
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(7, 0)) << 2) | 32'($urandom_range(3, 0));
            is_wr = ($urandom_range(1, 0) == 1) || !model_mem.exists(key(s, a));
            apply_stimulus(s, is_wr, a, $urandom, int'($urandom_range(3, 0)), $urandom_range(1, 0) == 1);
        end

        repeat (5) @(negedge CLK);
        check_output("pending_acks", 32'(q0.size() + q1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
